// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery modular multiplier.
// Holds the default operand width, the mode encodings and the FSM state types.
package mont_pkg;

  localparam int unsigned KBitsDefault = 8;

  // Mode 3 is an alias of mode 0 (plain product).
  typedef enum logic [1:0] {
    ModePlain    = 2'd0,
    ModeToMont   = 2'd1,
    ModeFromMont = 2'd2,
    ModeAlias    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StIssue1,
    StWait1,
    StIssue2,
    StWait2,
    StDone
  } seq_state_e;

  typedef enum logic [1:0] {
    CoreIdle,
    CoreIter,
    CoreReduce
  } core_state_e;

endpackage

// File: rtl/mont_mul_core.sv
// Bit-serial Montgomery product P = X*Y*R^-1 mod m, R = 2^K_BITS.
// Ports:
//   i_Clk, i_Rst  - clock, asynchronous active-high reset
//   i_Start       - sampled when idle; latches X, Y, m and clears the accumulator
//   i_X, i_Y, i_m - operands and odd modulus
//   o_P           - result, valid while o_Done is high and held until the next start
//   o_Done        - one-cycle pulse after the final conditional subtract
// Timing: start sampled on edge e, iterations on e+1..e+K, reduction on e+K+1.
module mont_mul_core
  import mont_pkg::*;
#(
  parameter int unsigned K_BITS = KBitsDefault
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [K_BITS-1:0] i_X,
  input  logic [K_BITS-1:0] i_Y,
  input  logic [K_BITS-1:0] i_m,
  output logic [K_BITS-1:0] o_P,
  output logic              o_Done
);

  localparam int unsigned AccW = K_BITS + 2;
  localparam int unsigned CntW = $clog2(K_BITS + 1);

  core_state_e      st_q, st_d;
  logic [K_BITS-1:0] x_q, x_d, y_q, y_d, m_q, m_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [AccW-1:0]   sum;

  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    m_d    = m_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;

    // One LSB-first step: add x_i*Y, make even with +m, then halve.
    // Accumulator stays below 2m, so the pre-shift sum fits in K+2 bits.
    sum = acc_q + (x_q[0] ? {2'b00, y_q} : '0);
    if (sum[0]) begin
      sum = sum + {2'b00, m_q};
    end

    unique case (st_q)
      CoreIdle: begin
        if (i_Start) begin
          x_d   = i_X;
          y_d   = i_Y;
          m_d   = i_m;
          acc_d = '0;
          cnt_d = '0;
          st_d  = CoreIter;
        end
      end
      CoreIter: begin
        acc_d = sum >> 1;
        x_d   = x_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(K_BITS - 1)) begin
          st_d = CoreReduce;
        end
      end
      CoreReduce: begin
        if (acc_q >= {2'b00, m_q}) begin
          acc_d = acc_q - {2'b00, m_q};
        end
        done_d = 1'b1;
        st_d   = CoreIdle;
      end
      default: st_d = CoreIdle;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      st_q   <= CoreIdle;
      x_q    <= '0;
      y_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      m_q    <= m_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign o_P    = acc_q[K_BITS-1:0];
  assign o_Done = done_q;

endmodule

// File: rtl/mont_modmul_seq.sv
// Sequencer around mont_mul_core for plain, to- and from-Montgomery products.
// Ports:
//   i_Clk, i_Rst        - clock, asynchronous active-high reset
//   i_Start             - request strobe, only sampled in idle
//   i_Mode              - 0/3: A*B mod m, 1: A*R mod m, 2: A*R^-1 mod m
//   i_A, i_B, i_m, i_R2 - operands, odd modulus, R^2 mod m
//   o_P                 - registered result, held until the next completion
//   o_Done              - one-cycle completion pulse
//   o_Busy              - high whenever not idle
module mont_modmul_seq
  import mont_pkg::*;
#(
  parameter int unsigned K_BITS = KBitsDefault
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic [1:0]        i_Mode,
  input  logic [K_BITS-1:0] i_A,
  input  logic [K_BITS-1:0] i_B,
  input  logic [K_BITS-1:0] i_m,
  input  logic [K_BITS-1:0] i_R2,
  output logic [K_BITS-1:0] o_P,
  output logic              o_Done,
  output logic              o_Busy
);

  seq_state_e        st_q, st_d;
  mode_e             mode_q;
  logic [K_BITS-1:0] a_q, b_q, m_q, r2_q, r1_q, p_q;
  logic              two_pass;
  logic              core_start, core_done;
  logic [K_BITS-1:0] core_x, core_y, core_p;

  assign two_pass = (mode_q == ModePlain) || (mode_q == ModeAlias);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:   if (i_Start) st_d = StIssue1;
      StIssue1: st_d = StWait1;
      StWait1:  if (core_done) st_d = two_pass ? StIssue2 : StDone;
      StIssue2: st_d = StWait2;
      StWait2:  if (core_done) st_d = StDone;
      StDone:   st_d = StIdle;
      default:  st_d = StIdle;
    endcase
  end

  // First pass converts A (times R2) or strips R (times 1); second pass multiplies by B.
  always_comb begin
    core_start = (st_q == StIssue1) || (st_q == StIssue2);
    if (st_q == StIssue2) begin
      core_x = r1_q;
      core_y = b_q;
    end else begin
      core_x = a_q;
      core_y = (mode_q == ModeFromMont) ? K_BITS'(1) : r2_q;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      st_q   <= StIdle;
      mode_q <= ModePlain;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      r2_q   <= '0;
      r1_q   <= '0;
      p_q    <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == StIdle && i_Start) begin
        mode_q <= mode_e'(i_Mode);
        a_q    <= i_A;
        b_q    <= i_B;
        m_q    <= i_m;
        r2_q   <= i_R2;
      end
      if (st_q == StWait1 && core_done) begin
        r1_q <= core_p;
      end
      if (st_d == StDone && st_q != StDone) begin
        p_q <= core_p;
      end
    end
  end

  mont_mul_core #(
    .K_BITS(K_BITS)
  ) u_core (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Start(core_start),
    .i_X    (core_x),
    .i_Y    (core_y),
    .i_m    (m_q),
    .o_P    (core_p),
    .o_Done (core_done)
  );

  assign o_P    = p_q;
  assign o_Done = (st_q == StDone);
  assign o_Busy = (st_q != StIdle);

endmodule

// File: doc/mont_modmul_seq.md
MONT_MODMUL_SEQ -- requirements
Module: mont_modmul_seq

Interface
REQ-001 The parameter K_BITS SHALL default to 8 and set the operand and modulus width in bits.
REQ-002 The port i_Clk SHALL be an input, 1 bit wide, and is the single rising-edge clock.
REQ-003 The port i_Rst SHALL be an input, 1 bit wide, and is the asynchronous, active-high reset.
REQ-004 The port i_Start SHALL be an input, 1 bit wide, and is the request strobe, sampled only in IDLE.
REQ-005 The port i_Mode SHALL be an input, 2 bits wide, with encodings 0=plain A*B mod m, 1=to-Montgomery A*R mod m, 2=from-Montgomery A*R^-1 mod m, 3=treated as 0.
REQ-006 The ports i_A, i_B, i_m and i_R2 SHALL be inputs, each K_BITS wide, carrying the operands, the odd modulus and R^2 mod m (R=2^K_BITS).
REQ-007 The port o_P SHALL be an output, K_BITS wide, carrying the registered result.
REQ-008 The port o_Done SHALL be an output, 1 bit wide, and is the completion pulse.
REQ-009 The port o_Busy SHALL be an output, 1 bit wide, and SHALL be high whenever the state is not IDLE.

Function
REQ-010 When i_Start=1 in IDLE, the block SHALL latch i_A, i_B, i_m, i_R2 and i_Mode on that edge; it SHALL ignore later input changes until the next accepted start.
REQ-011 The block SHALL use the states IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2 and DONE.
REQ-012 The state transitions SHALL be: IDLE to ISSUE1 on start; ISSUE1 to WAIT1; WAIT1 to ISSUE2 on core done when mode is 0 or 3, otherwise WAIT1 to DONE; ISSUE2 to WAIT2; WAIT2 to DONE on core done; DONE to IDLE.
REQ-013 The first core operation SHALL be MM(A,R2) in modes 0, 1 and 3, and MM(A,1) in mode 2.
REQ-014 The second core operation (modes 0 and 3 only) SHALL be MM(result1, B).
REQ-015 The core Montgomery product MM(X,Y) SHALL equal X*Y*R^-1 mod m, computed bit-serially LSB-first: P+=x_i*Y; if P is odd then P+=m; P>>=1.
REQ-016 The core SHALL run K_BITS iterations followed by one conditional-subtract cycle (if P>=m then P-=m).
REQ-017 The core accumulator SHALL be K_BITS+2 bits wide and no intermediate value SHALL be truncated.
REQ-018 The core SHALL sample its start on edge e, iterate on edges e+1..e+K, reduce on edge e+K+1, and hold its done high for the one cycle following edge e+K+1.
REQ-019 The end-to-end latency SHALL be: o_Done high in the cycle after edge K+3 for modes 1 and 2, and after edge 2K+6 for modes 0 and 3, where edge 0 samples i_Start; for K=8 these are 11 and 22 cycles.
REQ-020 o_Done SHALL be high for exactly one cycle (the DONE state), and o_P SHALL be valid in that same cycle.
REQ-021 o_P SHALL hold its value until the next completion.
REQ-022 i_Start asserted while o_Busy=1 SHALL be ignored and SHALL NOT queue a request.
REQ-023 i_Start held high through DONE SHALL be accepted on the first IDLE edge after DONE; back-to-back operation SHALL therefore have a one-cycle gap.
REQ-024 The results SHALL be correct for A=0, for B=0 and for A,B in the range 0..m-1.
REQ-025 If m is even or an operand is >=m, the result SHALL be unspecified, but the latency and o_Done SHALL be unchanged.

Reset
REQ-026 Asserting i_Rst SHALL immediately force the state to IDLE and set o_P=0, o_Done=0, o_Busy=0, and clear the core accumulator, counter and done.
REQ-027 A reset asserted mid-operation SHALL abort the operation with no o_Done pulse, and the first start after release SHALL execute normally.

Structure
REQ-028 The shared package mont_pkg SHALL hold the K_BITS default, the mode encodings and the state enumeration.
REQ-029 The core SHALL be a separate sub-module, mont_mul_core, with ports i_Clk, i_Rst, i_Start, i_X, i_Y, i_m, o_P and o_Done.
REQ-030 The sequencer SHALL contain only the FSM, the operand registers and the operand multiplexing to the core.

Verification (K_BITS=8, R=256)
REQ-031 The bench SHALL apply mode 0 with A=10, B=11, m=225, R2=61 and SHALL require o_P=110 with o_Done 22 cycles after start.
REQ-032 The bench SHALL apply mode 1 with A=10, m=225, R2=61 and SHALL require o_P=85, then apply mode 2 with A=85, m=225 and SHALL require o_P=10, with o_Done 11 cycles after start in both cases.
REQ-033 The bench SHALL apply mode 0 with A=10, B=20, m=101, R2=88 and SHALL require o_P=99, then apply A=0, B=198, m=225 and SHALL require o_P=0.
REQ-034 The bench SHALL pulse i_Start again 5 cycles into a mode-0 run with different operands and SHALL require that run to be ignored, with one o_Done and the first result only.
REQ-035 The bench SHALL assert i_Rst 7 cycles into a mode-0 run and SHALL require o_Busy=0 and o_P=0 immediately with no o_Done, followed by a correct result (110) after restart.
